// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//   Handshake bundle for the nibble-serial adder.
//   Operand side : in_valid/in_ready with a, b, cin (sampled on the accept edge)
//   Result side  : out_valid/out_ready with sum, cout
//   Status       : busy (operation in flight or result waiting)
//   master : the client that supplies operands and consumes results
//   slave  : the adder itself
interface nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two WIDTH-bit unsigned operands plus a carry-in, one 4-bit nibble per
//   clock, through a single 4-bit adder slice. The carry between nibbles is
//   registered, and the result is collected into a shift register that fills
//   from the top, so after NIB steps the least significant nibble sits at bit 0.
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous, active-high reset (aborts any operation)
//     bus  - slave side of nibble_serial_adder_if:
//            in_valid/in_ready/a/b/cin  operand handshake (accepted only in IDLE)
//            out_valid/out_ready/sum/cout  result handshake (held until taken)
//            busy  high while an operation is running or its result is waiting
//   Result appears NIB edges after the accept edge; one operation per NIB+2
//   cycles at best, since operands and results never overlap.
module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input logic                  clk,
    input logic                  rst,
    nibble_serial_adder_if.slave bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             cout_reg;
    logic             out_valid_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             in_ready_int;
    logic             busy_int;
    logic             accept;
    logic             last_nib;
    logic             result_taken;
    logic [4:0]       nib_sum;

    // Single 4-bit slice: low nibbles of the shift registers plus carry.
    assign nib_sum  = {1'b0, a_sh_reg[3:0]} + {1'b0, b_sh_reg[3:0]} + {4'b0000, carry_reg};

    assign accept       = bus.in_valid && in_ready_int;
    assign last_nib     = (cnt_reg == CNT_W'(NIB - 1));
    assign result_taken = out_valid_reg && bus.out_ready;

    // Result shift register: every nibble moves down one slot and the fresh
    // nibble enters at the top. For WIDTH=4 the top slot is the only slot.
    generate
        for (genvar gi = 0; gi < NIB; gi++) begin : g_sum_shift
            if (gi == NIB - 1) begin : g_top
                assign sum_next[4*gi +: 4] = nib_sum[3:0];
            end else begin : g_mid
                assign sum_next[4*gi +: 4] = sum_reg[4*(gi+1) +: 4];
            end
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)       state_next = ST_RUN;
            ST_RUN:  if (last_nib)     state_next = ST_DONE;
            ST_DONE: if (result_taken) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        in_ready_int = 1'b0;
        busy_int     = 1'b0;
        case (state_reg)
            ST_IDLE: in_ready_int = 1'b1;
            ST_RUN:  busy_int     = 1'b1;
            ST_DONE: busy_int     = 1'b1;
            default: in_ready_int = 1'b0;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            cout_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= bus.b;
                        carry_reg <= bus.cin;
                        cnt_reg   <= '0;
                    end
                end
                ST_RUN: begin
                    sum_reg   <= sum_next;
                    carry_reg <= nib_sum[4];
                    a_sh_reg  <= a_sh_reg >> 4;
                    b_sh_reg  <= b_sh_reg >> 4;
                    if (last_nib) begin
                        // Counter parks at NIB-1; it is reloaded on the next accept.
                        cout_reg      <= nib_sum[4];
                        out_valid_reg <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (result_taken) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.busy      = busy_int;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum       = sum_reg;
    assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder_if #(.WIDTH(16)) ifc16 ();
    nibble_serial_adder_if #(.WIDTH(4))  ifc4 ();

    nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(ifc16));
    nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(ifc4));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    // One full 16-bit operation with bp cycles of backpressure in DONE;
    // a pulsed in_valid (a=0x1111) during backpressure must be ignored.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input int bp, input bit pulse);
        logic [16:0] exp;
        int          n;
        logic [15:0] held_sum;
        logic        held_cout;
        exp = 17'(a) + 17'(b) + 17'(cin);
        check("in_ready_idle", ifc16.in_ready, 1);
        ifc16.a = a; ifc16.b = b; ifc16.cin = cin;
        ifc16.in_valid = 1'b1;
        ifc16.out_ready = 1'b0;
        @(posedge clk); #1;
        ifc16.in_valid = 1'b0;
        ifc16.a = 16'($urandom); ifc16.b = 16'($urandom); ifc16.cin = 1'($urandom);
        n = 0;
        while (!ifc16.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, 4);
        check("sum", ifc16.sum, {16'h0, exp[15:0]});
        check("cout", ifc16.cout, exp[16]);
        held_sum  = ifc16.sum;
        held_cout = ifc16.cout;
        for (int i = 0; i < bp; i++) begin
            if (pulse) begin
                ifc16.in_valid = 1'b1;
                ifc16.a = 16'h1111;
            end
            @(posedge clk); #1;
            ifc16.in_valid = 1'b0;
            check("bp_valid", ifc16.out_valid, 1);
            check("bp_sum", ifc16.sum, held_sum);
            check("bp_cout", ifc16.cout, held_cout);
            check("bp_in_ready", ifc16.in_ready, 0);
            check("bp_busy", ifc16.busy, 1);
        end
        ifc16.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc16.out_ready = 1'b0;
        check("post_valid", ifc16.out_valid, 0);
        check("post_in_ready", ifc16.in_ready, 1);
        check("post_busy", ifc16.busy, 0);
        check("post_sum_hold", ifc16.sum, held_sum);
        $display("op16 a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d (exp %05h) bp=%0d",
                 a, b, cin, held_sum, held_cout, exp, bp);
    endtask

    initial begin
        logic [15:0] ra, rb;
        int          n;
        int          prev_acc;
        int          acc;
        logic [4:0]  e4;
        logic [3:0]  a4, b4;
        logic        c4;

        ifc16.in_valid = 1'b0; ifc16.out_ready = 1'b0;
        ifc16.a = '0; ifc16.b = '0; ifc16.cin = 1'b0;
        ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b0;
        ifc4.a = '0; ifc4.b = '0; ifc4.cin = 1'b0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", ifc16.in_ready, 1);
        check("rst_out_valid", ifc16.out_valid, 0);
        check("rst_sum", ifc16.sum, 0);
        check("rst_cout", ifc16.cout, 0);
        check("rst_busy", ifc16.busy, 0);

        // Directed cases
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1, 1'b0);
        run_op(16'h8000, 16'h8000, 1'b0, 0, 1'b0);
        run_op(16'h0F0F, 16'h00F1, 1'b0, 5, 1'b1);

        // Reset while cnt==2
        ifc16.a = 16'hABCD; ifc16.b = 16'h1357; ifc16.cin = 1'b1;
        ifc16.in_valid = 1'b1;
        @(posedge clk); #1;
        ifc16.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_valid", ifc16.out_valid, 0);
        check("midrst_sum", ifc16.sum, 0);
        check("midrst_busy", ifc16.busy, 0);
        check("midrst_in_ready", ifc16.in_ready, 1);
        $display("reset mid-RUN applied");
        run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

        // Randomized operations against the arithmetic model
        for (int k = 0; k < 20; k++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (k == 0) begin ra = 16'hFFFF; rb = 16'h0001; end
            run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
        end

        // WIDTH=4 instance, in_valid and out_ready held high
        ifc4.out_ready = 1'b1;
        prev_acc = 0;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (!ifc4.in_ready && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("w4_ready_wait", (n < 20) ? 1 : 0, 1);
            if (k == 0) begin a4 = 4'h9; b4 = 4'h8; c4 = 1'b1; end
            else begin a4 = 4'($urandom); b4 = 4'($urandom); c4 = 1'($urandom); end
            e4 = 5'(a4) + 5'(b4) + 5'(c4);
            ifc4.a = a4; ifc4.b = b4; ifc4.cin = c4;
            ifc4.in_valid = 1'b1;
            @(posedge clk); #1;
            acc = cyc;
            if (k > 0) check("w4_spacing", acc - prev_acc, 3);
            prev_acc = acc;
            n = 0;
            while (!ifc4.out_valid && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            check("w4_latency", n, 1);
            check("w4_sum", ifc4.sum, {28'h0, e4[3:0]});
            check("w4_cout", ifc4.cout, e4[4]);
            $display("op4 a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d (exp %02h)",
                     a4, b4, c4, ifc4.sum, ifc4.cout, e4);
        end
        ifc4.in_valid = 1'b0;
        @(posedge clk); #1;
        check("w4_idle", ifc4.in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
